// File: rtl/sisc_pkg.sv
// Shared SISC definitions: mem_arb state encoding, port ids and WAIT limits.
// Used by mem_arb and mem_arb_pick (MEM_ARB_RR_EN selects round-robin arbitration).
package sisc_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ISSUE = 2'd1;
    localparam arb_state_t ST_WAIT  = 2'd2;
    localparam arb_state_t ST_RESP  = 2'd3;

    // Port ids double as bit positions in the one-hot winner vector.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int WAIT_MIN   = 1;
    localparam int WAIT_MAX   = 15;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data ports.
// MEM_ARB_RR_EN: ties go to the port named by ptr; otherwise the data port always wins ties.
module mem_arb_pick
    import sisc_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       ptr,
    output logic [1:0] winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        winner = 2'b00;
        if (if_req && d_req) begin
            winner[ptr] = 1'b1;
        end else if (d_req) begin
            winner[PORT_D] = 1'b1;
        end else if (if_req) begin
            winner[PORT_IF] = 1'b1;
        end
    end
`else
    logic ptr_unused;
    assign ptr_unused = ptr;

    always_comb begin
        winner = 2'b00;
        if (d_req) begin
            winner[PORT_D] = 1'b1;
        end else if (if_req) begin
            winner[PORT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed data-port priority.
module mem_arb
    import sisc_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT - 1);

    arb_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [1:0]            winner;
    logic                  ptr;
    logic                  start;
    logic                  win_d;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  issue;
    logic                  resp;
    logic                  last_wait;

    mem_arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_req),
        .ptr    (ptr),
        .winner (winner)
    );

    assign start     = (state == ST_IDLE) && (|winner);
    assign issue     = (state == ST_ISSUE);
    assign resp      = (state == ST_RESP);
    assign last_wait = (state == ST_WAIT) && (wait_cnt == '0);

`ifdef MEM_ARB_RR_EN
    // The port just granted becomes the loser of the next tie.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ptr <= PORT_D;
        end else if (start) begin
            ptr <= winner[PORT_D] ? PORT_IF : PORT_D;
        end
    end
`else
    assign ptr = PORT_D;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_ISSUE;
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) state <= ST_RESP;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            win_d   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            win_d   <= winner[PORT_D];
            we_q    <= winner[PORT_D] && d_we;
            addr_q  <= winner[PORT_D] ? d_addr : if_addr;
            wdata_q <= d_wdata;
        end
    end

    // Stores leave d_rdata untouched so the last load word stays visible.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (last_wait) begin
            if (!win_d)     if_rdata <= mem_rdata;
            else if (!we_q) d_rdata  <= mem_rdata;
        end
    end

    assign mem_en    = issue;
    assign mem_we    = issue && we_q;
    assign mem_addr  = issue ? addr_q : '0;
    assign mem_wdata = (issue && we_q) ? wdata_q : '0;
    assign if_gnt    = issue && !win_d;
    assign d_gnt     = issue && win_d;
    assign if_valid  = resp && !win_d;
    assign d_valid   = resp && win_d;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: vector table on a WAIT=1 instance, plus reset,
// arbitration and WAIT=3 latency sequences. Expected tie order follows MEM_ARB_RR_EN.
module tb_mem_arb;
    import sisc_pkg::*;

    logic        clk;
    logic        rst_f;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        w3_if_req, w3_d_req, w3_d_we;
    logic [15:0] w3_if_addr, w3_d_addr;
    logic [31:0] w3_d_wdata;
    logic        w3_if_gnt, w3_if_valid, w3_d_gnt, w3_d_valid;
    logic [31:0] w3_if_rdata, w3_d_rdata;
    logic        w3_mem_en, w3_mem_we;
    logic [15:0] w3_mem_addr;
    logic [31:0] w3_mem_wdata, w3_mem_rdata;

    logic [31:0] mem [256];

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wdata;
        logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] if_rdata, d_rdata;
    } vec_t;

    vec_t vecs[21];

    mem_arb #(.ADDR_W(16), .DATA_W(32), .WAIT(1)) u_dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arb #(.ADDR_W(16), .DATA_W(32), .WAIT(3)) u_dut_w3 (
        .clk(clk), .rst_f(rst_f),
        .if_req(w3_if_req), .if_addr(w3_if_addr), .if_gnt(w3_if_gnt), .if_valid(w3_if_valid), .if_rdata(w3_if_rdata),
        .d_req(w3_d_req), .d_we(w3_d_we), .d_addr(w3_d_addr), .d_wdata(w3_d_wdata),
        .d_gnt(w3_d_gnt), .d_valid(w3_d_valid), .d_rdata(w3_d_rdata),
        .mem_en(w3_mem_en), .mem_we(w3_mem_we), .mem_addr(w3_mem_addr), .mem_wdata(w3_mem_wdata), .mem_rdata(w3_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: one cycle read latency, write on enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (w3_mem_en && !w3_mem_we) w3_mem_rdata <= mem[w3_mem_addr[7:0]];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int i, input logic ir, input logic [15:0] ia, input logic dr,
                           input logic dw, input logic [15:0] da, input logic [31:0] dd,
                           input logic ig, input logic iv, input logic dg, input logic dv,
                           input logic me, input logic mw, input logic [15:0] ma,
                           input logic [31:0] md, input logic [31:0] ird, input logic [31:0] drd);
        vecs[i].if_req = ir;  vecs[i].if_addr = ia;  vecs[i].d_req = dr;   vecs[i].d_we = dw;
        vecs[i].d_addr = da;  vecs[i].d_wdata = dd;  vecs[i].if_gnt = ig;  vecs[i].if_valid = iv;
        vecs[i].d_gnt = dg;   vecs[i].d_valid = dv;  vecs[i].mem_en = me;  vecs[i].mem_we = mw;
        vecs[i].mem_addr = ma; vecs[i].mem_wdata = md; vecs[i].if_rdata = ird; vecs[i].d_rdata = drd;
    endtask

    task automatic apply_stimulus(input int i);
        if_req  = vecs[i].if_req;
        if_addr = vecs[i].if_addr;
        d_req   = vecs[i].d_req;
        d_we    = vecs[i].d_we;
        d_addr  = vecs[i].d_addr;
        d_wdata = vecs[i].d_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i);
        check_output($sformatf("v%0d if_gnt", i),    {31'd0, if_gnt},   {31'd0, vecs[i].if_gnt});
        check_output($sformatf("v%0d if_valid", i),  {31'd0, if_valid}, {31'd0, vecs[i].if_valid});
        check_output($sformatf("v%0d d_gnt", i),     {31'd0, d_gnt},    {31'd0, vecs[i].d_gnt});
        check_output($sformatf("v%0d d_valid", i),   {31'd0, d_valid},  {31'd0, vecs[i].d_valid});
        check_output($sformatf("v%0d mem_en", i),    {31'd0, mem_en},   {31'd0, vecs[i].mem_en});
        check_output($sformatf("v%0d mem_we", i),    {31'd0, mem_we},   {31'd0, vecs[i].mem_we});
        check_output($sformatf("v%0d mem_addr", i),  {16'd0, mem_addr}, {16'd0, vecs[i].mem_addr});
        check_output($sformatf("v%0d mem_wdata", i), mem_wdata,         vecs[i].mem_wdata);
        check_output($sformatf("v%0d if_rdata", i),  if_rdata,          vecs[i].if_rdata);
        check_output($sformatf("v%0d d_rdata", i),   d_rdata,           vecs[i].d_rdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic order [4];
        logic exp_port;
        int   n_gnt;

        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        mem[8'h10] = 32'h12345678;
        mem[8'h04] = 32'hCAFEF00D;

        //          i  ir ia       dr dw da       dd            ig iv dg dv me mw ma       md            if_rdata      d_rdata
        add_vec( 0, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        1, 0, 0, 0, 1, 0, 16'h0010, 32'h0,        32'h0,        32'h0);
        add_vec( 1, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h0,        32'h0);
        add_vec( 2, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        0, 1, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec( 3, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec( 4, 1, 16'h0010, 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 1, 0, 1, 1, 16'h0020, 32'hDEADBEEF, 32'h12345678, 32'h0);
        add_vec( 5, 1, 16'h0010, 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec( 6, 1, 16'h0010, 1, 1, 16'h0020, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec( 7, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec( 8, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        1, 0, 0, 0, 1, 0, 16'h0010, 32'h0,        32'h12345678, 32'h0);
        add_vec( 9, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec(10, 1, 16'h0010, 0, 0, 16'h0000, 32'h0,        0, 1, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec(11, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec(12, 0, 16'h0000, 1, 0, 16'h0020, 32'h0,        0, 0, 1, 0, 1, 0, 16'h0020, 32'h0,        32'h12345678, 32'h0);
        add_vec(13, 0, 16'h0000, 1, 0, 16'h0020, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'h0);
        add_vec(14, 0, 16'h0000, 1, 0, 16'h0020, 32'h0,        0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hDEADBEEF);
        add_vec(15, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hDEADBEEF);
        add_vec(16, 0, 16'h0000, 1, 0, 16'h0004, 32'h0,        0, 0, 1, 0, 1, 0, 16'h0004, 32'h0,        32'h12345678, 32'hDEADBEEF);
        add_vec(17, 1, 16'h0030, 1, 0, 16'h0004, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hDEADBEEF);
        add_vec(18, 0, 16'h0000, 1, 0, 16'h0004, 32'h0,        0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hCAFEF00D);
        add_vec(19, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hCAFEF00D);
        add_vec(20, 0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        32'h12345678, 32'hCAFEF00D);

        w3_if_req = 0; w3_if_addr = '0; w3_d_req = 0; w3_d_we = 0; w3_d_addr = '0; w3_d_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; if_addr = 16'h0010;

        // Requests asserted during reset must not be granted.
        rst_f  = 1'b0;
        if_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset if_gnt", {31'd0, if_gnt}, 32'd0);
        check_output("reset mem_en", {31'd0, mem_en}, 32'd0);
        check_output("reset if_rdata", if_rdata, 32'd0);
        check_output("reset d_rdata", d_rdata, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(i);
            check_vec(i);
        end

        // Continuous contention from a fresh reset.
        rst_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
        n_gnt = 0;
        for (int c = 0; c < 20 && n_gnt < 4; c++) begin
            @(posedge clk);
            #1;
            if (d_gnt) begin
                order[n_gnt] = PORT_D;
                n_gnt++;
            end else if (if_gnt) begin
                order[n_gnt] = PORT_IF;
                n_gnt++;
            end
        end
        check_output("contention grant count", n_gnt, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_port = (k % 2 == 0) ? PORT_D : PORT_IF;
`else
            exp_port = PORT_D;
`endif
            if (k < n_gnt) check_output($sformatf("contention grant %0d port", k), {31'd0, order[k]}, {31'd0, exp_port});
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of a fetch's WAIT state.
        if_req = 1'b1; if_addr = 16'h0010;
        @(posedge clk); #1;
        check_output("rstwait issue if_gnt", {31'd0, if_gnt}, 32'd1);
        @(posedge clk); #2;
        rst_f = 1'b0;
        #1;
        check_output("rstwait mem_en", {31'd0, mem_en}, 32'd0);
        check_output("rstwait if_valid", {31'd0, if_valid}, 32'd0);
        check_output("rstwait d_valid", {31'd0, d_valid}, 32'd0);
        check_output("rstwait if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        rst_f = 1'b1;
        @(posedge clk); #1;
        check_output("rstwait regrant if_gnt", {31'd0, if_gnt}, 32'd1);
        check_output("rstwait regrant mem_addr", {16'd0, mem_addr}, 32'h0010);
        @(posedge clk); #1;
        check_output("rstwait wait if_valid", {31'd0, if_valid}, 32'd0);
        @(posedge clk); #1;
        check_output("rstwait resp if_valid", {31'd0, if_valid}, 32'd1);
        check_output("rstwait resp if_rdata", if_rdata, 32'h12345678);
        if_req = 1'b0;
        @(posedge clk); #1;

        // WAIT=3 load: grant after edge 1, single valid pulse after edge 5.
        w3_d_req = 1'b1; w3_d_we = 1'b0; w3_d_addr = 16'h0004;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("w3 edge%0d d_gnt", k), {31'd0, w3_d_gnt}, {31'd0, (k == 1)});
            check_output($sformatf("w3 edge%0d d_valid", k), {31'd0, w3_d_valid}, {31'd0, (k == 5)});
            if (k == 5) begin
                check_output("w3 d_rdata", w3_d_rdata, 32'hCAFEF00D);
                w3_d_req = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter WAIT, default 1, memory read latency in cycles after issue; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_f  in  1  reset, asynchronous, active-low.
REQ-006 if_req  in  1 / if_addr  in  ADDR_W  instruction-fetch request and address, held until if_valid.
REQ-007 if_gnt  out  1 / if_valid  out  1 / if_rdata  out  DATA_W  fetch grant pulse, completion pulse, fetched word.
REQ-008 d_req  in  1 / d_we  in  1 / d_addr  in  ADDR_W / d_wdata  in  DATA_W  data-port (LOD/STR) request, held until d_valid.
REQ-009 d_gnt  out  1 / d_valid  out  1 / d_rdata  out  DATA_W  data grant pulse, completion pulse, load word.
REQ-010 mem_en  out  1 / mem_we  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  DATA_W / mem_rdata  in  DATA_W  single-port synchronous memory.

Function
REQ-011 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when any req high at a clock edge; ISSUE->WAIT; WAIT->RESP after WAIT cycles in WAIT; RESP->IDLE unconditionally.
REQ-012 Arbitration only in IDLE; winner, address, we and wdata latched on IDLE->ISSUE edge; requests are not sampled in other states.
REQ-013 Default priority: data port wins when both requests high in the same cycle.
REQ-014 ISSUE: mem_en=1, mem_addr/mem_wdata from latched values, mem_we=latched we (data port only; always 0 for fetch), winner's gnt=1 for exactly that cycle.
REQ-015 mem_en, mem_we, gnt SHALL be 0 in IDLE, WAIT and RESP.
REQ-016 Last WAIT cycle: mem_rdata captured into winner's rdata register on the closing edge.
REQ-017 RESP: winner's valid=1 for exactly one cycle; rdata stable from RESP until the next completion on that port.
REQ-018 Store completion: d_valid pulses in RESP; d_rdata unchanged by stores.
REQ-019 Latency: request high in IDLE at cycle N -> gnt at N+1, valid at N+2+WAIT; back-to-back throughput one access per WAIT+3 cycles.
REQ-020 Request still high in RESP cycle is treated as a new request at the following IDLE.
REQ-021 Request withdrawn before being latched is ignored; a latched access always completes.
REQ-022 WAIT counter 4 bits, loads WAIT-1 on ISSUE->WAIT, decrements to 0; no wrap.

Reset
REQ-023 rst_f low asynchronously forces state IDLE, all outputs 0, rdata registers 0, round-robin pointer to data-port preference.
REQ-024 Reset during ISSUE/WAIT/RESP aborts the access: no valid pulse, mem_en drops immediately.
REQ-025 First arbitration at the first clock edge after rst_f rises.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin on simultaneous requests; port granted last loses the next tie; pointer updates on IDLE->ISSUE.
REQ-027 Macro absent: fixed data-port priority per REQ-013; no pointer register built.

Structure
REQ-028 Shared package sisc_pkg holds the mem_arb state typedef, port-id constants (PORT_IF, PORT_D) and the WAIT range limit.
REQ-029 One combinational sub-module mem_arb_pick: inputs if_req, d_req, pointer; output one-hot winner; contains the MEM_ARB_RR_EN selection.

Verification
REQ-030 Fetch only, WAIT=1, if_addr=0x0010, mem word 0x12345678 -> if_gnt at N+1, if_valid at N+3, if_rdata=0x12345678.
REQ-031 Both requests at cycle N, d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF -> d_gnt at N+1 with mem_we=1; if_gnt no earlier than N+5.
REQ-032 With MEM_ARB_RR_EN, both requests held continuously -> grants alternate D, IF, D, IF; without it -> D every access, IF starved.
REQ-033 WAIT=3, data load from 0x0004 -> d_valid exactly at N+5, single pulse.
REQ-034 rst_f low during WAIT -> mem_en=0 and all valids 0 immediately; after release, held if_req granted one cycle after first edge.
REQ-035 if_req pulsed one cycle while state is WAIT -> never granted.
